// File: rtl/seg_display_scheduler.sv
// Round-robin shares the two-digit seven-segment display between two 32-bit word sources,
// scrolling each granted word MSB byte first with a fixed per-byte dwell time.
module seg_display_scheduler #(
  parameter int unsigned DWELL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  input  logic        hold,
  output logic [7:0]  disp_byte,
  output logic [1:0]  byte_idx,
  output logic        src,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(DWELL);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           state;
  logic [31:0]      word;
  logic [CNT_W-1:0] cnt;
  logic             prio;     // 1: req1 wins a tie
  logic             grant1;
  logic [31:0]      gdata;
  logic [1:0]       nxt_idx;

  always_comb begin
    grant1  = req1 && (!req0 || prio);
    gdata   = grant1 ? data1 : data0;
    nxt_idx = byte_idx - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      cnt       <= '0;
      prio      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      disp_byte <= '0;
      byte_idx  <= 2'd3;
      src       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            word      <= gdata;
            ack0      <= !grant1;
            ack1      <= grant1;
            src       <= grant1;
            prio      <= !grant1;
            byte_idx  <= 2'd3;
            cnt       <= '0;
            disp_byte <= gdata[31:24];
            busy      <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (!hold) begin
            if (cnt == CNT_W'(DWELL - 1)) begin
              cnt <= '0;
              if (byte_idx != 2'd0) begin
                byte_idx  <= nxt_idx;
                disp_byte <= word[{nxt_idx, 3'b000} +: 8];
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
